// File: rtl/imem_boot_loader.sv
// Streams a byte-wide program image into instruction memory as little-endian words,
// then releases the CPU from reset for a fixed number of cycles.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int RUN_CYCLES = 100
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  input  logic                  image_last,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_reset,
  output logic                  running,
  output logic                  done,
  output logic                  overflow
);

  localparam int CNT_W = (RUN_CYCLES < 1) ? 1 : $clog2(RUN_CYCLES + 1);
  localparam logic [CNT_W-1:0]      RUN_LAST  = CNT_W'((RUN_CYCLES < 1) ? 0 : RUN_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  typedef enum logic [2:0] {
    S_LOAD,
    S_RELEASE,
    S_RUN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                r_state;
  logic [1:0]            r_byte_cnt;
  logic [31:0]           r_word;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CNT_W-1:0]      r_run_cnt;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic                  r_cpu_reset;
  logic                  r_running;
  logic                  r_done;
  logic                  r_overflow;

  logic                  w_accept;
  logic                  w_word_end;
  logic [31:0]           w_word_full;

  assign byte_ready  = (r_state == S_LOAD) && !reset;
  assign w_accept    = byte_valid && byte_ready;
  assign w_word_end  = image_last || (r_byte_cnt == 2'd3);
  // The partial word buffer is cleared after every write, so unwritten lanes are zero padding.
  assign w_word_full = r_word | ({24'd0, byte_in} << {r_byte_cnt, 3'b000});

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_LOAD;
      r_byte_cnt  <= 2'd0;
      r_word      <= 32'd0;
      r_addr      <= '0;
      r_run_cnt   <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
      r_cpu_reset <= 1'b1;
      r_running   <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (w_accept) begin
            if (w_word_end) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_addr;
              r_mem_wdata <= w_word_full;
              r_word      <= 32'd0;
              r_byte_cnt  <= 2'd0;
              // The write cycle itself already runs in the next state, so no byte slips in behind it.
              if (image_last) begin
                r_state <= S_RELEASE;
                r_addr  <= r_addr + ADDR_WIDTH'(4);
              end else if (r_addr == LAST_ADDR) begin
                r_state    <= S_ERROR;
                r_overflow <= 1'b1;
              end else begin
                r_addr <= r_addr + ADDR_WIDTH'(4);
              end
            end else begin
              r_word     <= w_word_full;
              r_byte_cnt <= r_byte_cnt + 2'd1;
            end
          end
        end
        S_RELEASE: begin
          r_run_cnt <= '0;
          if (RUN_CYCLES < 1) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state     <= S_RUN;
            r_cpu_reset <= 1'b0;
            r_running   <= 1'b1;
          end
        end
        S_RUN: begin
          if (r_run_cnt == RUN_LAST) begin
            r_state     <= S_DONE;
            r_cpu_reset <= 1'b1;
            r_running   <= 1'b0;
            r_done      <= 1'b1;
          end else begin
            r_run_cnt <= r_run_cnt + CNT_W'(1);
          end
        end
        S_DONE, S_ERROR: begin
          r_state <= r_state;
        end
        default: begin
          r_state     <= S_ERROR;
          r_cpu_reset <= 1'b1;
          r_running   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_reset = r_cpu_reset;
  assign running   = r_running;
  assign done      = r_done;
  assign overflow  = r_overflow;

endmodule
